// File: rtl/bus_arbiter8_pkg.sv
// Shared definitions for the eight-source round-robin bus arbiter.
package bus_arbiter8_pkg;

  localparam int unsigned NSRC = 8;
  localparam int unsigned SELW = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  function automatic logic [NSRC-1:0] onehot(input logic [SELW-1:0] idx);
    return NSRC'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter8_rr_pick8.sv
// Combinational round-robin finder: first set request after ptr, wrapping mod 8.
module rr_pick8
  import bus_arbiter8_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [2*NSRC-1:0] dbl;
  logic [NSRC-1:0]   rot;
  logic [SELW:0]     sh;
  logic [SELW-1:0]   off;

  // rot[k] is req[(ptr+1+k) mod 8], so the lowest set bit is the winner
  always_comb begin
    dbl   = {req, req};
    sh    = (SELW+1)'(ptr) + (SELW+1)'(1);
    rot   = dbl[sh +: NSRC];
    off   = '0;
    found = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = SELW'(k);
        found = 1'b1;
      end
    end
    idx = SELW'(ptr + SELW'(1) + off);
  end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter muxing eight DW-bit sources onto one registered bus.
// Optional macro ARB_PREEMPT_EN forces release after MAX_HOLD data cycles when others wait.
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HW       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC-1:0]    req,
  input  logic [NSRC*DW-1:0] din,
  output logic [NSRC-1:0]    grant,
  output logic [SELW-1:0]    sel,
  output logic               busy,
  output logic [DW-1:0]      dout,
  output logic               out_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || HW >= 32 || (32'd1 << HW) <= MAX_HOLD) begin : g_bad_cfg
    $error("bus_arbiter8: MAX_HOLD/HW out of range");
  end

  logic [0:0]      state, state_nxt;
  logic [NSRC-1:0] grant_nxt;
  logic [SELW-1:0] sel_nxt, ptr, ptr_nxt, pick;
  logic            busy_nxt, out_valid_nxt, found, preempt_c, release_c;
  logic [DW-1:0]   dout_nxt;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick),
    .found (found)
  );

`ifdef ARB_PREEMPT_EN
  // hold_cnt counts data cycles already presented on dout for the current owner
  logic [HW-1:0] hold_cnt, hold_nxt;
  assign preempt_c = (hold_cnt == HW'(MAX_HOLD - 1)) && ((req & ~grant) != '0);
`else
  assign preempt_c = 1'b0;
`endif

  assign release_c = !req[sel] || preempt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
      ptr       <= SELW'(NSRC - 1);
`ifdef ARB_PREEMPT_EN
      hold_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      sel       <= sel_nxt;
      busy      <= busy_nxt;
      dout      <= dout_nxt;
      out_valid <= out_valid_nxt;
      ptr       <= ptr_nxt;
`ifdef ARB_PREEMPT_EN
      hold_cnt  <= hold_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    sel_nxt       = sel;
    busy_nxt      = busy;
    dout_nxt      = dout;
    out_valid_nxt = out_valid;
    ptr_nxt       = ptr;
`ifdef ARB_PREEMPT_EN
    hold_nxt      = hold_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt     = ST_GRANT;
          grant_nxt     = onehot(pick);
          sel_nxt       = pick;
          ptr_nxt       = pick;
          busy_nxt      = 1'b1;
          out_valid_nxt = 1'b0;
`ifdef ARB_PREEMPT_EN
          hold_nxt      = '0;
`endif
        end
      end
      ST_GRANT: begin
        // Release always passes through IDLE, giving the one-cycle turnaround
        if (release_c) begin
          state_nxt     = ST_IDLE;
          grant_nxt     = '0;
          busy_nxt      = 1'b0;
          out_valid_nxt = 1'b0;
        end else begin
          dout_nxt      = din[sel*DW +: DW];
          out_valid_nxt = 1'b1;
`ifdef ARB_PREEMPT_EN
          if (out_valid && hold_cnt != '1)
            hold_nxt = hold_cnt + HW'(1);
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8 with a per-cycle reference model (MAX_HOLD=4).
module tb_bus_arbiter8;

  localparam int unsigned DW = 32;
  localparam int unsigned MH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      req;
  logic [8*DW-1:0] din;
  logic [7:0]      grant;
  logic [2:0]      sel;
  logic            busy;
  logic [DW-1:0]   dout;
  logic            out_valid;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  bus_arbiter8 #(.DW(DW), .MAX_HOLD(MH), .HW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .grant     (grant),
    .sel       (sel),
    .busy      (busy),
    .dout      (dout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 when idle), last winner, words delivered
  int            m_owner = -1;
  int            m_ptr   = 7;
  int            m_sel   = 0;
  int            m_words = 0;
  logic [DW-1:0] m_dout  = '0;
  bit            m_ov    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_ptr = 7; m_sel = 0; m_words = 0; m_dout = '0; m_ov = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 8; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
        end
      end
      if (m_owner >= 0) begin
        m_ptr = m_owner; m_sel = m_owner; m_words = 0; m_ov = 1'b0;
      end
    end else begin
      bit rel;
      rel = !req[m_owner];
`ifdef ARB_PREEMPT_EN
      if (m_words == MH && (req & ~(8'(1) << m_owner)) != 8'h00) rel = 1'b1;
`endif
      if (rel) begin
        m_owner = -1; m_ov = 1'b0;
      end else begin
        m_dout  = din[m_owner*DW +: DW];
        m_ov    = 1'b1;
        m_words = m_words + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle after the first reset edge, outputs must match the model
  always @(negedge clk) begin
    if (started) begin
      check("model_grant", 64'(grant), (m_owner < 0) ? 64'h0 : (64'h1 << m_owner));
      check("model_sel", 64'(sel), 64'(m_sel));
      check("model_busy", 64'(busy), 64'(m_owner >= 0));
      check("model_dout", 64'(dout), 64'(m_dout));
      check("model_valid", 64'(out_valid), 64'(m_ov));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o;
    int cnt;
    int bad;
    rst = 1'b1;
    req = 8'h00;
    for (int i = 0; i < 8; i++) din[i*DW +: DW] = {16'hA5A5, 16'(i + 1)};
    step(1);
    started = 1'b1;
    step(1);
    rst = 1'b0;

    // 1: reset values, first grant and first data word
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_sel", 64'(sel), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_valid", 64'(out_valid), 64'h0);
    req = 8'h01;
    step(1);
    check("t1_grant", 64'(grant), 64'h01);
    check("t1_sel", 64'(sel), 64'h0);
    check("t1_valid_lag", 64'(out_valid), 64'h0);
    step(1);
    check("t1_valid", 64'(out_valid), 64'h1);
    check("t1_dout", 64'(dout), 64'hA5A5_0001);
    req = 8'h00;
    step(1);
    check("t1_release", 64'(grant), 64'h0);
    check("t1_dout_hold", 64'(dout), 64'hA5A5_0001);

    // 2: full rotation with one IDLE cycle between owners
    do_reset();
    req = 8'hFF;
    step(1);
    for (int i = 0; i <= 8; i++) begin
      o = i % 8;
      check("t2_owner", 64'(grant), 64'h1 << o);
      if (i == 8) break;
      step(2);
      req[o] = 1'b0;
      step(1);
      check("t2_turnaround", 64'(grant), 64'h0);
      req[o] = 1'b1;
      step(1);
    end
    req = 8'h00;
    step(2);

    // 3: owner drops while another raises in the same cycle
    do_reset();
    req = 8'h08;
    step(1);
    check("t3_owner3", 64'(grant), 64'h08);
    step(2);
    req = 8'h20;
    step(1);
    check("t3_idle", 64'(grant), 64'h0);
    step(1);
    check("t3_grant5", 64'(grant), 64'h20);
    check("t3_sel5", 64'(sel), 64'h5);
    req = 8'h00;
    step(2);

    // 4: two requesters held constantly
    do_reset();
    req = 8'h06;
    step(1);
    check("t4_owner1", 64'(grant), 64'h02);
`ifdef ARB_PREEMPT_EN
    for (int r = 0; r < 3; r++) begin
      cnt = 0;
      for (int s = 0; s < 20; s++) begin
        step(1);
        if (grant == 8'h00) break;
        if (out_valid) cnt++;
      end
      check("t4_words", 64'(cnt), 64'(MH));
      check("t4_idle", 64'(grant), 64'h0);
      step(1);
      check("t4_next_owner", 64'(grant), (r % 2 == 0) ? 64'h04 : 64'h02);
    end
`else
    step(30);
    check("t4_hold_grant", 64'(grant), 64'h02);
    check("t4_hold_valid", 64'(out_valid), 64'h1);
    check("t4_hold_dout", 64'(dout), 64'hA5A5_0002);
`endif
    req = 8'h00;
    step(2);

    // 5: lone requester is never preempted
    do_reset();
    req = 8'h10;
    step(1);
    bad = 0;
    for (int s = 0; s < 40; s++) begin
      step(1);
      if (grant != 8'h10) bad++;
    end
    check("t5_lone_cycles_lost", 64'(bad), 64'h0);
    check("t5_dout", 64'(dout), 64'hA5A5_0005);
    req = 8'h00;
    step(2);

    // 6: reset mid-grant, then pointer restarts at source 0
    do_reset();
    req = 8'h40;
    step(1);
    check("t6_owner6", 64'(grant), 64'h40);
    step(2);
    rst = 1'b1;
    req = 8'h41;
    step(1);
    check("t6_rst_grant", 64'(grant), 64'h0);
    check("t6_rst_sel", 64'(sel), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_dout", 64'(dout), 64'h0);
    check("t6_rst_valid", 64'(out_valid), 64'h0);
    rst = 1'b0;
    step(1);
    check("t6_grant0", 64'(grant), 64'h01);
    check("t6_sel0", 64'(sel), 64'h0);
    req = 8'h00;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
